// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: write-back arbiter and hazard scoreboard for a
// single-write-port register file.
//   - Requester 0 (ALU) and requester 1 (load unit) share one write port.
//     Contention between them is resolved round-robin.
//   - The winner is registered onto rf_write_en/rf_regw/rf_dataw. The
//     register file captures that value one edge later.
//   - A per-register busy vector is set at issue and cleared at write-back.
//     It drives the operand-stale flags for decode.
// Handshake: a transfer happens on any cycle with wbX_valid && wbX_ready.
// wbX_ready is combinational from the valid inputs and rr_ptr only. Once a
// requester raises valid, it holds valid/reg/data stable until it sees ready.
// Optional feature macro: ZERO_REG_EN. When it is defined, register 0 is
// hardwired to zero.
module regfile_wb_scheduler #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc_en,
    input  logic [REG_ADDR_WIDTH-1:0] alloc_reg,
    input  logic                      wb0_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb0_reg,
    input  logic [DATA_WIDTH-1:0]     wb0_data,
    output logic                      wb0_ready,
    input  logic                      wb1_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb1_reg,
    input  logic [DATA_WIDTH-1:0]     wb1_data,
    output logic                      wb1_ready,
    input  logic [REG_ADDR_WIDTH-1:0] rd_reg1,
    input  logic [REG_ADDR_WIDTH-1:0] rd_reg2,
    output logic                      rd_busy1,
    output logic                      rd_busy2,
    output logic                      rf_write_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_regw,
    output logic [DATA_WIDTH-1:0]     rf_dataw,
    output logic [REG_ADDR_WIDTH:0]   pending_cnt,
    output logic                      alloc_err
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [NUM_REGS-1:0]       busy_q, busy_d;
    logic                      rr_ptr_q, rr_ptr_d;
    logic                      rf_write_en_q, rf_write_en_d;
    logic [REG_ADDR_WIDTH-1:0] rf_regw_q, rf_regw_d;
    logic [DATA_WIDTH-1:0]     rf_dataw_q, rf_dataw_d;
    logic [REG_ADDR_WIDTH:0]   pending_cnt_q, pending_cnt_d;
    logic                      alloc_err_q, alloc_err_d;

    logic                      gnt0, gnt1, any_gnt;
    logic [REG_ADDR_WIDTH-1:0] gnt_reg;
    logic [DATA_WIDTH-1:0]     gnt_data;
    logic                      alloc_ok;

    // Round-robin grant: a lone requester always wins, and rr_ptr breaks ties.
    always_comb begin
        gnt0     = wb0_valid && (!wb1_valid || !rr_ptr_q);
        gnt1     = wb1_valid && (!wb0_valid ||  rr_ptr_q);
        any_gnt  = gnt0 || gnt1;
        gnt_reg  = gnt1 ? wb1_reg  : wb0_reg;
        gnt_data = gnt1 ? wb1_data : wb0_data;
        rr_ptr_d = rr_ptr_q;
        if (gnt0) begin
            rr_ptr_d = 1'b1;
        end else if (gnt1) begin
            rr_ptr_d = 1'b0;
        end
    end

    // Write-port stage: a grant loads the port. A write to the hardwired
    // zero register is accepted but never reaches the file.
    always_comb begin
        rf_write_en_d = 1'b0;
        rf_regw_d     = rf_regw_q;
        rf_dataw_d    = rf_dataw_q;
        if (any_gnt && !(ZERO_REG && gnt_reg == '0)) begin
            rf_write_en_d = 1'b1;
            rf_regw_d     = gnt_reg;
            rf_dataw_d    = gnt_data;
        end
    end

    // Scoreboard update. The clear is applied before the set, so a
    // same-register alloc in the same cycle wins.
    always_comb begin
        alloc_ok      = alloc_en && !(ZERO_REG && alloc_reg == '0);
        busy_d        = busy_q;
        alloc_err_d   = alloc_err_q;
        pending_cnt_d = '0;
        if (any_gnt) begin
            busy_d[gnt_reg] = 1'b0;
        end
        if (alloc_ok) begin
            busy_d[alloc_reg] = 1'b1;
            // A register that is being released this very cycle is not a
            // double allocation.
            if (busy_q[alloc_reg] && !(any_gnt && gnt_reg == alloc_reg)) begin
                alloc_err_d = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_cnt_d = pending_cnt_d + {{REG_ADDR_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            rr_ptr_q      <= 1'b0;
            rf_write_en_q <= 1'b0;
            rf_regw_q     <= '0;
            rf_dataw_q    <= '0;
            pending_cnt_q <= '0;
            alloc_err_q   <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            rf_write_en_q <= rf_write_en_d;
            rf_regw_q     <= rf_regw_d;
            rf_dataw_q    <= rf_dataw_d;
            pending_cnt_q <= pending_cnt_d;
            alloc_err_q   <= alloc_err_d;
        end
    end

    // Operand hazard: the register is stale while it is busy, and also during
    // the cycle its value sits on the write port before the file captures it.
    always_comb begin
        rd_busy1 = (busy_q[rd_reg1] || (rf_write_en_q && rf_regw_q == rd_reg1))
                   && !(ZERO_REG && rd_reg1 == '0);
        rd_busy2 = (busy_q[rd_reg2] || (rf_write_en_q && rf_regw_q == rd_reg2))
                   && !(ZERO_REG && rd_reg2 == '0);
    end

    assign wb0_ready   = gnt0;
    assign wb1_ready   = gnt1;
    assign rf_write_en = rf_write_en_q;
    assign rf_regw     = rf_regw_q;
    assign rf_dataw    = rf_dataw_q;
    assign pending_cnt = pending_cnt_q;
    assign alloc_err   = alloc_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: directed vectors. The expected
// write-port traffic is queued at issue time and popped by a monitor.
module tb_regfile_wb_scheduler;

  localparam int RAW = 4;
  localparam int DW = 8;
  localparam int W = RAW + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic alloc_en;
  logic [RAW-1:0] alloc_reg;
  logic wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [RAW-1:0] wb0_reg, wb1_reg, rd_reg1, rd_reg2, rf_regw;
  logic [DW-1:0] wb0_data, wb1_data, rf_dataw;
  logic rd_busy1, rd_busy2, rf_write_en, alloc_err;
  logic [RAW:0] pending_cnt;

  regfile_wb_scheduler #(.REG_ADDR_WIDTH(RAW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_en(alloc_en), .alloc_reg(alloc_reg),
    .wb0_valid(wb0_valid), .wb0_reg(wb0_reg), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_reg(wb1_reg), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .rf_write_en(rf_write_en), .rf_regw(rf_regw), .rf_dataw(rf_dataw),
    .pending_cnt(pending_cnt), .alloc_err(alloc_err)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cnt6 = 0;
  int cnt7 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every write-port cycle must match the head of the queue
  always @(negedge clk) begin
    if (rst_n && rf_write_en) begin
      if (rf_regw == 4'd6) cnt6++;
      if (rf_regw == 4'd7) cnt7++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'd0, rf_regw, rf_dataw}, 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("write_port", {20'd0, rf_regw, rf_dataw}, {20'd0, e});
      end
    end
  end

  // driver tasks
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    alloc_en = 1'b0;
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_alloc(input logic [RAW-1:0] r);
    @(negedge clk);
    alloc_en = 1'b1;
    alloc_reg = r;
    @(negedge clk);
    alloc_en = 1'b0;
  endtask

  initial begin
    alloc_en = 0; alloc_reg = 0;
    wb0_valid = 0; wb0_reg = 0; wb0_data = 0;
    wb1_valid = 0; wb1_reg = 0; wb1_data = 0;
    rd_reg1 = 0; rd_reg2 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset in the middle of a cycle while a write-back is in flight
    rd_reg1 = 4'd5;
    do_alloc(4'd5);
    wb0_valid = 1'b1; wb0_reg = 4'd9; wb0_data = 8'h11;
    @(posedge clk);
    #1;
    check("pre_reset_we", rf_write_en, 1);
    check("pre_reset_pending", pending_cnt, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_we", rf_write_en, 0);
    check("rst_regw", rf_regw, 0);
    check("rst_dataw", rf_dataw, 0);
    check("rst_pending", pending_cnt, 0);
    check("rst_alloc_err", alloc_err, 0);
    check("rst_rd_busy1", rd_busy1, 0);
    @(negedge clk);
    wb0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_we", rf_write_en, 0);

    // single write
    rd_reg1 = 4'd1;
    @(negedge clk);
    alloc_en = 1'b1; alloc_reg = 4'd1;
    #1 check("sw_busy_before_alloc", rd_busy1, 0);
    @(negedge clk);
    alloc_en = 1'b0;
    check("sw_busy_after_alloc", rd_busy1, 1);
    check("sw_pending_1", pending_cnt, 1);
    wb0_valid = 1'b1; wb0_reg = 4'd1; wb0_data = 8'hFF;
    #1 check("sw_ready", wb0_ready, 1);
    exp_q.push_back({4'd1, 8'hFF});
    @(negedge clk);
    wb0_valid = 1'b0;
    check("sw_busy_during_we", rd_busy1, 1);
    check("sw_pending_0", pending_cnt, 0);
    @(negedge clk);
    check("sw_busy_after_we", rd_busy1, 0);

    // contention from reset: wb0 then wb1
    reset_dut();
    @(negedge clk);
    wb0_valid = 1'b1; wb0_reg = 4'd2; wb0_data = 8'hAB;
    wb1_valid = 1'b1; wb1_reg = 4'd3; wb1_data = 8'hCD;
    #1;
    check("ct_ready0", wb0_ready, 1);
    check("ct_ready1_blocked", wb1_ready, 0);
    exp_q.push_back({4'd2, 8'hAB});
    @(negedge clk);
    wb0_valid = 1'b0;
    #1 check("ct_ready1", wb1_ready, 1);
    exp_q.push_back({4'd3, 8'hCD});
    @(negedge clk);
    wb1_valid = 1'b0;

    // fairness: both valid for 6 cycles, the pointer should be back at 0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wb0_valid = 1'b1; wb0_reg = 4'd6; wb0_data = 8'h60;
      wb1_valid = 1'b1; wb1_reg = 4'd7; wb1_data = 8'h70;
      #1;
      check("fair_ready0", wb0_ready, (i % 2 == 0) ? 1 : 0);
      check("fair_ready1", wb1_ready, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) exp_q.push_back({4'd6, 8'h60});
      else exp_q.push_back({4'd7, 8'h70});
    end
    @(negedge clk);
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    @(negedge clk);
    check("fair_cnt0", cnt6, 3);
    check("fair_cnt1", cnt7, 3);

    // simultaneous set/clear on reg 4
    rd_reg2 = 4'd4;
    do_alloc(4'd4);
    alloc_en = 1'b1; alloc_reg = 4'd4;
    wb1_valid = 1'b1; wb1_reg = 4'd4; wb1_data = 8'h44;
    #1 check("sc_ready1", wb1_ready, 1);
    exp_q.push_back({4'd4, 8'h44});
    @(negedge clk);
    alloc_en = 1'b0; wb1_valid = 1'b0;
    check("sc_pending", pending_cnt, 1);
    check("sc_no_err", alloc_err, 0);
    @(negedge clk);
    check("sc_still_busy", rd_busy2, 1);
    do_alloc(4'd4);
    check("sc_err_set", alloc_err, 1);
    check("sc_pending_again", pending_cnt, 1);

    // write-back to a non-busy register leaves the scoreboard alone
    wb0_valid = 1'b1; wb0_reg = 4'd9; wb0_data = 8'h99;
    #1 check("nb_ready0", wb0_ready, 1);
    exp_q.push_back({4'd9, 8'h99});
    @(negedge clk);
    wb0_valid = 1'b0;
    @(negedge clk);
    check("nb_pending", pending_cnt, 1);
    check("sc_err_sticky", alloc_err, 1);
    check("nb_busy4", rd_busy2, 1);

    // register 0
    reset_dut();
    rd_reg1 = 4'd0;
    do_alloc(4'd0);
`ifdef ZERO_REG_EN
    check("z_busy", rd_busy1, 0);
    check("z_pending", pending_cnt, 0);
    do_alloc(4'd0);
    check("z_no_err", alloc_err, 0);
    wb0_valid = 1'b1; wb0_reg = 4'd0; wb0_data = 8'h55;
    #1 check("z_ready", wb0_ready, 1);
    @(negedge clk);
    wb0_valid = 1'b0;
    check("z_we", rf_write_en, 0);
    check("z_busy_after", rd_busy1, 0);
    check("z_pending_after", pending_cnt, 0);
`else
    check("r0_busy", rd_busy1, 1);
    check("r0_pending", pending_cnt, 1);
    wb0_valid = 1'b1; wb0_reg = 4'd0; wb0_data = 8'h55;
    #1 check("r0_ready", wb0_ready, 1);
    exp_q.push_back({4'd0, 8'h55});
    @(negedge clk);
    wb0_valid = 1'b0;
    check("r0_busy_we", rd_busy1, 1);
    check("r0_pending_after", pending_cnt, 0);
`endif

    // pending_cnt at full scale
    reset_dut();
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      alloc_en = 1'b1; alloc_reg = RAW'(r);
    end
    @(negedge clk);
    alloc_en = 1'b0;
`ifdef ZERO_REG_EN
    check("full_pending", pending_cnt, 15);
`else
    check("full_pending", pending_cnt, 16);
`endif
    check("full_no_err", alloc_err, 0);

    // report
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Write-back scheduler and hazard scoreboard for the single-write-port register file. Two write-back sources share the one write port: requester 0 is the ALU and requester 1 is the load unit. Arbitration is round-robin. The registered winner drives write_en/regw/dataw of register_file. A per-register busy scoreboard, set at issue and cleared at write-back, tells decode when a source operand is stale.

Parameters:
REG_ADDR_WIDTH, 4, register index width; NUM_REGS = 1 << REG_ADDR_WIDTH
DATA_WIDTH, 8, register data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alloc_en  in  1  issue stage marks a destination register pending
alloc_reg  in  REG_ADDR_WIDTH  destination register being allocated
wb0_valid  in  1  ALU result valid
wb0_reg  in  REG_ADDR_WIDTH  ALU destination register
wb0_data  in  DATA_WIDTH  ALU result
wb0_ready  out  1  ALU result accepted this cycle
wb1_valid  in  1  load result valid
wb1_reg  in  REG_ADDR_WIDTH  load destination register
wb1_data  in  DATA_WIDTH  load result
wb1_ready  out  1  load result accepted this cycle
rd_reg1  in  REG_ADDR_WIDTH  decode source operand 1
rd_reg2  in  REG_ADDR_WIDTH  decode source operand 2
rd_busy1  out  1  operand 1 not yet readable
rd_busy2  out  1  operand 2 not yet readable
rf_write_en  out  1  to register_file write_en
rf_regw  out  REG_ADDR_WIDTH  to register_file regw
rf_dataw  out  DATA_WIDTH  to register_file dataw
pending_cnt  out  REG_ADDR_WIDTH+1  number of busy bits currently set
alloc_err  out  1  sticky flag: alloc to an already-busy register

Behaviour:
- Reset (rst_n low, asynchronous): busy vector = 0, rr_ptr = 0, rf_write_en = 0, rf_regw = 0, rf_dataw = 0, pending_cnt = 0, alloc_err = 0. Any write-back in flight is dropped.
- Handshake: a transfer occurs when wbX_valid && wbX_ready. wbX_ready is combinational and depends only on the valid inputs and rr_ptr. Once valid is raised, the requester holds valid/reg/data stable until ready.
- Arbitration:
  - At most one grant per cycle.
  - Exactly one valid: grant that requester.
  - Both valid: grant requester rr_ptr.
  - rr_ptr updates on every grant to the non-granted index.
  - Neither valid: no grant, rr_ptr holds.
- Write port stage:
  - At the edge where a grant occurs: rf_write_en = 1, rf_regw/rf_dataw = granted reg/data.
  - Otherwise rf_write_en = 0; rf_regw/rf_dataw hold.
  - Latency: accept at edge N, rf_write_en high during cycle N..N+1, register_file captures at edge N+1.
- Scoreboard:
  - alloc_en sets busy[alloc_reg] at the edge.
  - An accepted write-back clears busy[wbX_reg] at the same edge.
  - Alloc and clear of the same register in the same cycle: set wins.
  - Write-back to a non-busy register: written normally, busy unchanged.
  - Alloc to a register already busy: busy stays 1, alloc_err sets and stays set until reset.
- Read hazard (combinational): rd_busyK = busy[rd_regK] | (rf_write_en && rf_regw == rd_regK). The second term covers the cycle before register_file captures the value.
- pending_cnt: registered population count of the busy vector, consistent with it every cycle. Range 0..NUM_REGS without overflow.

Optional Feature:
ZERO_REG_EN
- Defined:
  - Register 0 is hardwired zero.
  - alloc to reg 0 is ignored (busy[0] never sets, no alloc_err).
  - Write-backs to reg 0 are accepted (ready asserted per arbitration) but produce rf_write_en = 0.
  - rd_busyK is always 0 for reg 0.
- Undefined: register 0 is an ordinary register, with no special cases.

Test Plan:
- Reset check: assert rst_n = 0 mid-cycle with wb0_valid = 1. All outputs are 0 immediately. After release, with no valids, rf_write_en stays 0.
- Single write: alloc reg 1, then wb0 {reg 1, 8'hFF}. wb0_ready = 1 that cycle. rf_write_en = 1, rf_regw = 1, rf_dataw = FF the next cycle. rd_busy1 (rd_reg1 = 1) stays 1 from the alloc edge through the rf_write_en cycle, then 0. pending_cnt goes 1 -> 0.
- Contention: wb0 {reg 2, AB} and wb1 {reg 3, CD} held valid together from reset. Grants are wb0 then wb1. rf_regw sequence is 2, 3 on consecutive cycles, and rr_ptr ends at 0.
- Fairness: both requesters continuously valid for 6 cycles. Grants alternate 0, 1, 0, 1, 0, 1, with exactly 3 rf_write_en pulses per requester.
- Simultaneous set/clear: busy reg 4 with wb1 {reg 4} accepted in the same cycle as alloc reg 4. busy[4] remains 1 and alloc_err = 0. A second alloc of reg 4 sets alloc_err = 1, sticky.
- With ZERO_REG_EN defined: alloc reg 0 then wb0 {reg 0, 55}. wb0_ready = 1, rf_write_en stays 0, rd_busy for reg 0 stays 0, pending_cnt stays 0.
